// File: rtl/sync_debounce_edge_det_pkg.sv
// Shared definitions for the synchronizer / debounce / edge-detect block:
// FSM state encoding, debounce counter width and default parameter values.
package sync_debounce_pkg;

  // Width of the debounce counter; DEBOUNCE-1 always fits (DEBOUNCE <= 255).
  localparam int CNT_W = 8;

  // Default parameter values shared by the top, the interface and benches.
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE    = 4;
  localparam int DEF_COUNT_W     = 4;

  // Debounce FSM states. S_CHK_* mean "a new value is being timed".
  typedef enum logic [1:0] {
    S_LO     = 2'b00,
    S_CHK_HI = 2'b01,
    S_HI     = 2'b10,
    S_CHK_LO = 2'b11
  } state_t;

endpackage

// File: rtl/sync_debounce_edge_det_if.sv
// Signal bundle between the raw-bit producer / downstream control logic
// (master) and the debounce block (slave).
interface sync_debounce_edge_det_if
  import sync_debounce_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) ();

  logic               d;
  logic               clr_count;
  logic               level;
  logic               rise;
  logic               fall;
  logic [COUNT_W-1:0] edge_count;

  // Producer/consumer side: drives the raw bit and the count clear.
  modport master (
    output d, clr_count,
    input  level, rise, fall, edge_count
  );

  // Debounce block side.
  modport slave (
    input  d, clr_count,
    output level, rise, fall, edge_count
  );

endinterface

// File: rtl/sync_debounce_edge_det_sync_chain.sv
// Plain flop shift chain used as a multi-stage synchronizer. No logic is
// placed between stages so each flop gets a full cycle to resolve.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_sync
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] stage;

  // Shift the raw bit in at stage 0 and along the chain every cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a real pipeline.
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], d_in};
    end
  end

  assign d_sync = stage[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce_edge_det.sv
// Synchronizes a possibly asynchronous / bouncing bit, debounces it with a
// four-state FSM and reports a clean level, one-cycle rise/fall pulses and a
// saturating count of accepted edges.
module sync_debounce_edge_det
  import sync_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int COUNT_W     = DEF_COUNT_W
) (
  input logic                     clk,
  input logic                     rst,
  sync_debounce_edge_det_if.slave bus
);

  if (DEBOUNCE < 2 || DEBOUNCE > 255) begin : g_bad_debounce
    $error("sync_debounce_edge_det: DEBOUNCE must be in 2..255");
  end
  if (COUNT_W < 1) begin : g_bad_count_w
    $error("sync_debounce_edge_det: COUNT_W must be at least 1");
  end

  // Counter value on the cycle that completes the DEBOUNCE-long run.
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic               sync_out;
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               accept_rise, accept_fall;
  logic               level_nxt;
  logic               level_q, rise_q, fall_q;
  logic [COUNT_W-1:0] edge_count_q;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk    (clk),
    .rst    (rst),
    .d_in   (bus.d),
    .d_sync (sync_out)
  );

  // FSM state and debounce counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: start timing on a change, abort on a bounce back,
  // accept once the new value has been seen DEBOUNCE times in a row.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_LO: begin
        if (sync_out) begin
          state_nxt = S_CHK_HI;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_CHK_HI: begin
        if (!sync_out) begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_HI: begin
        if (!sync_out) begin
          state_nxt = S_CHK_LO;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_CHK_LO: begin
        if (sync_out) begin
          state_nxt = S_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: acceptance events and the level they lead to.
  always_comb begin
    accept_rise = (state == S_CHK_HI) && sync_out && (cnt == CNT_LAST);
    accept_fall = (state == S_CHK_LO) && !sync_out && (cnt == CNT_LAST);
    level_nxt   = level_q;
    if (accept_rise) begin
      level_nxt = 1'b1;
    end else if (accept_fall) begin
      level_nxt = 1'b0;
    end
  end

  // Registered outputs; the edge counter steps on the same edge as the pulse
  // and a clear wins over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      edge_count_q <= '0;
    end else begin
      level_q <= level_nxt;
      rise_q  <= accept_rise;
      fall_q  <= accept_fall;
      if (bus.clr_count) begin
        edge_count_q <= '0;
      end else if ((accept_rise || accept_fall) && (edge_count_q != COUNT_MAX)) begin
        edge_count_q <= edge_count_q + COUNT_W'(1);
      end
    end
  end

  assign bus.level      = level_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.edge_count = edge_count_q;

endmodule
